ddr3_read_ctrl: RTL and testbench
=================================

# ddr3_read_ctrl

Read-side companion of the DDR3 initialization writer. It accepts a read job (base address and beat count) and splits it into chunked CMD_READ requests toward the DDR3 UI wrapper. It collects the returned 512-bit beats into an internal FIFO and streams them to a downstream consumer (feature or weight loader) over a valid/ready handshake. A new chunk is issued only when the FIFO has room for the whole chunk, because the DDR read data path cannot be back-pressured.

## Interface
- DDR_WIDTH, 64: DDR3 data width.
- UI_WIDTH, DDR_WIDTH*8: UI beat width (512).
- ADDR_WIDTH, 29: DDR address width.
- ADDR_STEP, 8: address increment per UI beat.
- FIFO_DEPTH, 16: buffer depth in beats; power of 2, at least 2.
- CHUNK, 8: maximum beats per issued read command; 1 ≤ CHUNK ≤ FIFO_DEPTH.

Ports (all synchronous to ui_clk; reset is synchronous and active-high):
- ui_clk  in  1  clock.
- ui_rst  in  1  synchronous active-high reset.
- rd_start  in  1  single-cycle job start; ignored unless in IDLE.
- rd_base_addr  in  ADDR_WIDTH  job start address, sampled with rd_start.
- rd_size  in  10  job length in beats, sampled with rd_start.
- ddr_rdy  in  1  DDR controller ready (calibration done, idle).
- ddr_rd_data  in  UI_WIDTH  returned read beat.
- ddr_rd_data_valid  in  1  ddr_rd_data qualifier; cannot be stalled.
- ddr_rd_finish  in  1  one-cycle pulse; current command fully returned.
- ddr_cmd  out  3  CMD_WRITE=0, CMD_READ=1, CMD_IDLE=2.
- ddr_cmd_valid  out  1  command active.
- ddr_base_addr  out  ADDR_WIDTH  chunk start address.
- ddr_size  out  10  chunk length in beats.
- out_data  out  UI_WIDTH  FIFO head.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  consumer accepts a beat when out_valid && out_ready.
- rd_busy  out  1  job in progress (not IDLE).
- rd_done  out  1  one-cycle pulse at job completion.
- err_overflow  out  1  sticky; a beat arrived while the FIFO was full.
- err_count  out  1  sticky; the beat count at ddr_rd_finish did not equal ddr_size.

## Operation
- Internal state: cur_addr, remaining (10 b), chunk_len, beat_cnt, FIFO count (log2(FIFO_DEPTH)+1 b).
- States: IDLE, ISSUE, WAIT, DRAIN.
- **IDLE**
  - On rd_start && ddr_rdy: latch cur_addr and remaining, clear both error flags, enter ISSUE.
  - If rd_size==0, go to DRAIN instead.
  - rd_start while ddr_rdy=0 is dropped.
- **ISSUE**
  - chunk_len = min(remaining, CHUNK).
  - When ddr_rdy && (FIFO_DEPTH - count) ≥ chunk_len:
    - drive ddr_cmd=CMD_READ, ddr_cmd_valid=1, ddr_base_addr=cur_addr, ddr_size=chunk_len;
    - clear beat_cnt;
    - enter WAIT.
- **WAIT**
  - Hold the command outputs and ddr_cmd_valid=1.
  - Each ddr_rd_data_valid increments beat_cnt and pushes the beat into the FIFO.
  - On ddr_rd_finish:
    - remaining -= chunk_len;
    - cur_addr += chunk_len*ADDR_STEP, truncated to ADDR_WIDTH (wraps);
    - ddr_cmd_valid=0, ddr_cmd=CMD_IDLE;
    - go to DRAIN if remaining==0, else ISSUE.
  - A ddr_rd_data_valid in the same cycle as ddr_rd_finish is counted as part of the current chunk.
- **DRAIN**: wait until the FIFO is empty, then pulse rd_done for one cycle and return to IDLE.
- **FIFO**
  - Push is accepted if not full, or if full with a pop in the same cycle.
  - A beat arriving while full with no pop is dropped and sets err_overflow.
  - Simultaneous push and pop leaves count unchanged.
- **Reset**: ui_rst mid-job aborts immediately, empties the FIFO and returns all outputs to reset values. Beats still in flight after reset are ignored, because the block is in IDLE.

## Timing
- Reset values: ddr_cmd=2, ddr_cmd_valid=0, ddr_base_addr=0, ddr_size=0, out_valid=0, out_data=0, rd_busy=0, rd_done=0, err_overflow=0, err_count=0.
- rd_start → ddr_cmd_valid=1: 2 cycles when the FIFO has room (IDLE→ISSUE, ISSUE→WAIT).
- ddr_rd_data_valid → out_valid: 1 cycle. The FIFO is first-word-fall-through from a registered store.
- ddr_rd_finish → next chunk's ddr_cmd_valid=1: at least 2 cycles, with ddr_cmd_valid low for at least 1 cycle between chunks.
- Last pop → rd_done: 1 cycle. rd_busy deasserts in the cycle after rd_done.
- Sustained throughput is 1 beat/cycle when out_ready=1.

## Configuration
- **DDR3_RD_BEATCHK_EN defined**:
  - beat_cnt is compared to chunk_len at ddr_rd_finish;
  - a mismatch sets err_count;
  - the block still advances by chunk_len.
- **DDR3_RD_BEATCHK_EN undefined**: the comparator is removed and err_count is tied to 0. Address and remaining are still advanced by chunk_len.

## Test plan
- **Single job, one chunk:** base=0x100, size=5, out_ready=1, 5 beats returned.
  - Exactly one command: addr 0x100, size 5.
  - 5 beats out in order.
  - rd_done pulses once; no errors.
- **Multi-chunk job:** base=0, size=20, CHUNK=8.
  - Three commands: (0,8), (64,8), (128,4).
  - 20 beats out in order; rd_done pulses once.
- **Back-pressure:** size=20, out_ready=0 until the FIFO holds 16 beats.
  - The third command is not issued until at least 4 beats are popped.
  - No err_overflow.
- **Overflow:** the model returns 17 beats for a size-16 read with out_ready=0.
  - err_overflow=1 and the 17th beat is dropped.
  - With DDR3_RD_BEATCHK_EN defined, err_count=1; without it, err_count=0.
- **Edge starts:**
  - size=0 → no command issued; rd_done pulses 2 cycles after rd_start.
  - rd_start with ddr_rdy=0 → ignored; rd_busy stays 0.
- **Reset mid-job:** assert ui_rst during WAIT of a size-20 job.
  - Next cycle: ddr_cmd_valid=0, ddr_cmd=2, out_valid=0.
  - A following size-3 job completes normally.

Source files
------------

// File: rtl/ddr3_read_ctrl.sv
// ddr3_read_ctrl: splits a read job into chunked CMD_READ requests and
// buffers returned beats in a FWFT FIFO. Optional macro: DDR3_RD_BEATCHK_EN.
module ddr3_read_ctrl #(
   parameter int DDR_WIDTH  = 64,
   parameter int UI_WIDTH   = DDR_WIDTH * 8,
   parameter int ADDR_WIDTH = 29,
   parameter int ADDR_STEP  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int CHUNK      = 8
) (
   input  logic                  ui_clk,
   input  logic                  ui_rst,
   input  logic                  rd_start,
   input  logic [ADDR_WIDTH-1:0] rd_base_addr,
   input  logic [9:0]            rd_size,
   input  logic                  ddr_rdy,
   input  logic [UI_WIDTH-1:0]   ddr_rd_data,
   input  logic                  ddr_rd_data_valid,
   input  logic                  ddr_rd_finish,
   output logic [2:0]            ddr_cmd,
   output logic                  ddr_cmd_valid,
   output logic [ADDR_WIDTH-1:0] ddr_base_addr,
   output logic [9:0]            ddr_size,
   output logic [UI_WIDTH-1:0]   out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  rd_busy,
   output logic                  rd_done,
   output logic                  err_overflow,
   output logic                  err_count
);

   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [2:0] CMD_READ = 3'd1;
   localparam logic [2:0] CMD_IDLE = 3'd2;

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DRAIN} state_t;

   state_t                state;
   logic [ADDR_WIDTH-1:0] cur_addr;
   logic [9:0]            remaining;
   logic [9:0]            chunk_len;
   logic [9:0]            chunk_nxt;
   logic [10:0]           room;
   logic                  can_issue;
   logic                  job_start;
   logic                  issue_evt;
   logic                  fin_evt;

   logic [UI_WIDTH-1:0]   mem [FIFO_DEPTH];
   logic [PTR_W-1:0]      wr_ptr;
   logic [PTR_W-1:0]      rd_ptr;
   logic [CNT_W-1:0]      count;
   logic                  full;
   logic                  beat_in;
   logic                  push;
   logic                  pop;

   assign full      = (count == CNT_W'(FIFO_DEPTH));
   assign out_valid = (count != '0);
   assign out_data  = out_valid ? mem[rd_ptr] : '0;
   assign pop       = out_valid && out_ready;
   assign beat_in   = (state == WAIT) && ddr_rd_data_valid;
   assign push      = beat_in && (!full || pop);

   assign chunk_nxt = (remaining > 10'(CHUNK)) ? 10'(CHUNK) : remaining;
   assign room      = 11'(FIFO_DEPTH) - 11'(count);
   assign can_issue = ddr_rdy && (room >= {1'b0, chunk_nxt});
   assign job_start = (state == IDLE) && rd_start && ddr_rdy;
   assign issue_evt = (state == ISSUE) && can_issue;
   assign fin_evt   = (state == WAIT) && ddr_rd_finish;

   // FIFO storage; contents need no reset since count gates the head
   always_ff @(posedge ui_clk) begin
      if (push) mem[wr_ptr] <= ddr_rd_data;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge ui_clk) begin
      if (ui_rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Job sequencing: issue chunks only when the FIFO can absorb them
   always_ff @(posedge ui_clk) begin
      if (ui_rst) begin
         state         <= IDLE;
         cur_addr      <= '0;
         remaining     <= '0;
         chunk_len     <= '0;
         ddr_cmd       <= CMD_IDLE;
         ddr_cmd_valid <= 1'b0;
         ddr_base_addr <= '0;
         ddr_size      <= '0;
         rd_busy       <= 1'b0;
         rd_done       <= 1'b0;
         err_overflow  <= 1'b0;
      end else begin
         rd_done <= 1'b0;
         if (beat_in && full && !pop) err_overflow <= 1'b1;
         unique case (state)
            IDLE: begin
               rd_busy <= 1'b0;
               if (job_start) begin
                  cur_addr     <= rd_base_addr;
                  remaining    <= rd_size;
                  err_overflow <= 1'b0;
                  rd_busy      <= 1'b1;
                  state        <= (rd_size == '0) ? DRAIN : ISSUE;
               end
            end
            ISSUE: begin
               if (can_issue) begin
                  ddr_cmd       <= CMD_READ;
                  ddr_cmd_valid <= 1'b1;
                  ddr_base_addr <= cur_addr;
                  ddr_size      <= chunk_nxt;
                  chunk_len     <= chunk_nxt;
                  state         <= WAIT;
               end
            end
            WAIT: begin
               if (ddr_rd_finish) begin
                  remaining     <= remaining - chunk_len;
                  cur_addr      <= cur_addr + ADDR_WIDTH'(chunk_len)
                                 * ADDR_WIDTH'(ADDR_STEP);
                  ddr_cmd_valid <= 1'b0;
                  ddr_cmd       <= CMD_IDLE;
                  state <= (remaining == chunk_len) ? DRAIN : ISSUE;
               end
            end
            DRAIN: begin
               if (count == '0) begin
                  rd_done <= 1'b1;
                  state   <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

`ifdef DDR3_RD_BEATCHK_EN
   logic [9:0] beat_cnt;
   logic [9:0] beat_tot;

   // a beat coinciding with finish belongs to the chunk being closed
   assign beat_tot = beat_cnt + {9'b0, ddr_rd_data_valid};

   // Per-chunk beat counting and length check at finish
   always_ff @(posedge ui_clk) begin
      if (ui_rst) begin
         beat_cnt  <= '0;
         err_count <= 1'b0;
      end else begin
         if (job_start) err_count <= 1'b0;
         if (issue_evt) beat_cnt <= '0;
         else if (beat_in) beat_cnt <= beat_cnt + 1'b1;
         if (fin_evt && (beat_tot != chunk_len)) err_count <= 1'b1;
      end
   end
`else
   assign err_count = 1'b0;
`endif

endmodule

// File: tb/tb_ddr3_read_ctrl.sv
// tb_ddr3_read_ctrl: directed + randomized checks of ddr3_read_ctrl
// against a queue model of the buffered beat stream.
module tb_ddr3_read_ctrl;

   localparam int AW   = 29;
   localparam int UW   = 512;
   localparam int CH   = 8;
   localparam int FD   = 16;
   localparam int STEP = 8;

   logic          ui_clk = 1'b0;
   logic          ui_rst = 1'b1;
   logic          rd_start;
   logic [AW-1:0] rd_base_addr;
   logic [9:0]    rd_size;
   logic          ddr_rdy;
   logic [UW-1:0] ddr_rd_data;
   logic          ddr_rd_data_valid;
   logic          ddr_rd_finish;
   logic [2:0]    ddr_cmd;
   logic          ddr_cmd_valid;
   logic [AW-1:0] ddr_base_addr;
   logic [9:0]    ddr_size;
   logic [UW-1:0] out_data;
   logic          out_valid;
   logic          out_ready;
   logic          rd_busy;
   logic          rd_done;
   logic          err_overflow;
   logic          err_count;

   ddr3_read_ctrl dut (
      .ui_clk(ui_clk), .ui_rst(ui_rst),
      .rd_start(rd_start), .rd_base_addr(rd_base_addr),
      .rd_size(rd_size), .ddr_rdy(ddr_rdy),
      .ddr_rd_data(ddr_rd_data),
      .ddr_rd_data_valid(ddr_rd_data_valid),
      .ddr_rd_finish(ddr_rd_finish),
      .ddr_cmd(ddr_cmd), .ddr_cmd_valid(ddr_cmd_valid),
      .ddr_base_addr(ddr_base_addr), .ddr_size(ddr_size),
      .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .rd_busy(rd_busy),
      .rd_done(rd_done), .err_overflow(err_overflow),
      .err_count(err_count)
   );

   always #5 ui_clk = ~ui_clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(string tag, logic [UW-1:0] obs,
                      logic [UW-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [UW-1:0] rnd512();
      logic [UW-1:0] r;
      for (int i = 0; i < UW / 32; i++) r[i*32 +: 32] = $urandom;
      return r;
   endfunction

   // consumer ready: random or forced
   bit   rdy_rand = 0;
   logic rdy_force = 1'b0;
   logic rnd_bit = 1'b0;
   assign out_ready = rdy_rand ? rnd_bit : rdy_force;
   always @(negedge ui_clk) rnd_bit = 1'($urandom_range(0, 1));

   // reference model: ordered buffer of beats, drop when full w/o pop
   logic [UW-1:0] mq[$];
   int  epoch = 0;
   int  popped = 0;
   int  done_cnt = 0;
   int  beat_ep = 0;
   int  m_n;
   bit  m_pop;
   bit  mon_en = 0;

   always @(posedge ui_clk) begin
      if (ui_rst) begin
         mq.delete();
         epoch++;
      end else begin
         m_n   = mq.size();
         m_pop = out_ready && (m_n > 0);
         if (m_pop) begin
            mq.delete(0);
            popped++;
         end
         if (ddr_rd_data_valid && beat_ep == epoch &&
             (m_n < FD || m_pop))
            mq.push_back(ddr_rd_data);
      end
   end

   always @(negedge ui_clk) begin
      if (mon_en) begin
         if (rd_done === 1'b1) done_cnt++;
         chk("out_valid", UW'(out_valid), UW'(mq.size() != 0));
         chk("out_data", out_data, (mq.size() != 0) ? mq[0] : '0);
      end
   end

   // DDR UI responder: logs each command, returns beats, then finish
   logic [AW-1:0] log_addr[$];
   logic [9:0]    log_size[$];
   bit  resp_busy = 0;
   int  beats_sent = 0;
   int  extra_at = -1;
   int  extra_n = 0;
   int  nb;
   int  r_ep;
   bit  fin_last;

   initial begin
      ddr_rd_data_valid = 1'b0;
      ddr_rd_finish = 1'b0;
      ddr_rd_data = '0;
      forever begin
         @(negedge ui_clk);
         if (ddr_cmd_valid === 1'b1 && ddr_cmd === 3'd1 && !ui_rst) begin
            resp_busy = 1;
            beats_sent = 0;
            log_addr.push_back(ddr_base_addr);
            log_size.push_back(ddr_size);
            nb = int'(ddr_size);
            if (log_addr.size() == extra_at) nb += extra_n;
            r_ep = epoch;
            fin_last = 1'($urandom_range(0, 1));
            for (int i = 0; i < nb; i++) begin
               if ($urandom_range(0, 3) == 0) @(negedge ui_clk);
               ddr_rd_data = rnd512();
               ddr_rd_data_valid = 1'b1;
               beat_ep = r_ep;
               beats_sent++;
               ddr_rd_finish = fin_last && (i == nb - 1);
               @(negedge ui_clk);
               ddr_rd_data_valid = 1'b0;
               ddr_rd_finish = 1'b0;
            end
            if (!fin_last) begin
               ddr_rd_finish = 1'b1;
               @(negedge ui_clk);
               ddr_rd_finish = 1'b0;
            end
            resp_busy = 0;
         end
      end
   end

   int j_b0, j_p0, j_d0;

   task automatic start_job(logic [AW-1:0] base, int size);
      j_b0 = log_addr.size();
      j_p0 = popped;
      j_d0 = done_cnt;
      @(negedge ui_clk);
      rd_base_addr = base;
      rd_size = 10'(size);
      rd_start = 1'b1;
      @(negedge ui_clk);
      rd_start = 1'b0;
   endtask

   task automatic check_cmds(string tag, logic [AW-1:0] base, int size);
      int n;
      logic [AW-1:0] ea;
      int es;
      n = (size + CH - 1) / CH;
      chk({tag, "_ncmd"}, UW'(log_addr.size() - j_b0), UW'(n));
      for (int k = 0; k < n; k++) begin
         if (j_b0 + k < log_addr.size()) begin
            ea = base + AW'(k * CH * STEP);
            es = (size - k * CH > CH) ? CH : size - k * CH;
            chk({tag, "_addr"}, UW'(log_addr[j_b0 + k]), UW'(ea));
            chk({tag, "_size"}, UW'(log_size[j_b0 + k]), UW'(es));
         end
      end
   endtask

   task automatic finish_job(string tag, logic [AW-1:0] base, int size,
                             int beats);
      for (int i = 0; i < 4000 && done_cnt == j_d0; i++)
         @(negedge ui_clk);
      repeat (2) @(negedge ui_clk);
      chk({tag, "_done"}, UW'(done_cnt - j_d0), UW'(1));
      chk({tag, "_busy"}, UW'(rd_busy), UW'(0));
      chk({tag, "_beats"}, UW'(popped - j_p0), UW'(beats));
      check_cmds(tag, base, size);
   endtask

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   int exp_ec;
   logic [AW-1:0] rb;
   int rs;

   initial begin
`ifdef DDR3_RD_BEATCHK_EN
      exp_ec = 1;
`else
      exp_ec = 0;
`endif
      rd_start = 1'b0;
      rd_base_addr = '0;
      rd_size = '0;
      ddr_rdy = 1'b1;
      repeat (3) @(negedge ui_clk);
      chk("rst_cmd", UW'(ddr_cmd), UW'(2));
      chk("rst_cmd_valid", UW'(ddr_cmd_valid), UW'(0));
      chk("rst_addr", UW'(ddr_base_addr), UW'(0));
      chk("rst_size", UW'(ddr_size), UW'(0));
      chk("rst_out_valid", UW'(out_valid), UW'(0));
      chk("rst_out_data", out_data, '0);
      chk("rst_busy", UW'(rd_busy), UW'(0));
      chk("rst_done", UW'(rd_done), UW'(0));
      chk("rst_ovf", UW'(err_overflow), UW'(0));
      chk("rst_ecnt", UW'(err_count), UW'(0));
      ui_rst = 1'b0;
      mon_en = 1;

      // single chunk, with start-to-command latency
      rdy_force = 1'b1;
      start_job(29'h100, 5);
      chk("lat_pre", UW'(ddr_cmd_valid), UW'(0));
      @(negedge ui_clk);
      chk("lat_cmd", UW'(ddr_cmd_valid), UW'(1));
      finish_job("one", 29'h100, 5, 5);
      chk("one_ovf", UW'(err_overflow), UW'(0));
      chk("one_ecnt", UW'(err_count), UW'(0));

      // multi chunk
      start_job(29'h0, 20);
      finish_job("multi", 29'h0, 20, 20);

      // random jobs with random consumer, plus address wrap
      rdy_rand = 1;
      for (int t = 0; t < 4; t++) begin
         rb = (t == 3) ? 29'h1FFFFFC0 : AW'($urandom);
         rs = (t == 3) ? 20 : $urandom_range(1, 40);
         start_job(rb, rs);
         finish_job("rand", rb, rs, rs);
         chk("rand_ovf", UW'(err_overflow), UW'(0));
      end
      rdy_rand = 0;

      // back-pressure: third chunk waits for room
      rdy_force = 1'b0;
      start_job(29'h2000, 20);
      for (int i = 0; i < 500 && mq.size() < FD; i++)
         @(negedge ui_clk);
      chk("bp_fill", UW'(out_valid), UW'(1));
      repeat (10) @(negedge ui_clk);
      chk("bp_hold_a", UW'(log_addr.size() - j_b0), UW'(2));
      rdy_force = 1'b1;
      repeat (3) @(negedge ui_clk);
      rdy_force = 1'b0;
      repeat (10) @(negedge ui_clk);
      chk("bp_pop3", UW'(popped - j_p0), UW'(3));
      chk("bp_hold_b", UW'(log_addr.size() - j_b0), UW'(2));
      rdy_force = 1'b1;
      @(negedge ui_clk);
      rdy_force = 1'b0;
      for (int i = 0; i < 50 && log_addr.size() - j_b0 < 3; i++)
         @(negedge ui_clk);
      chk("bp_third", UW'(log_addr.size() - j_b0), UW'(3));
      chk("bp_ovf", UW'(err_overflow), UW'(0));
      rdy_force = 1'b1;
      finish_job("bp", 29'h2000, 20, 20);

      // overflow: 17 beats returned for a 16-beat job
      rdy_force = 1'b0;
      extra_at = log_addr.size() + 2;
      extra_n = 1;
      start_job(29'h40, 16);
      for (int i = 0; i < 500 &&
           !(log_addr.size() - j_b0 == 2 && !resp_busy); i++)
         @(negedge ui_clk);
      repeat (3) @(negedge ui_clk);
      chk("ovf_flag", UW'(err_overflow), UW'(1));
      chk("ovf_ecnt", UW'(err_count), UW'(exp_ec));
      rdy_force = 1'b1;
      finish_job("ovf", 29'h40, 16, 16);
      chk("ovf_sticky", UW'(err_overflow), UW'(1));
      extra_at = -1;
      extra_n = 0;

      // zero-size job
      start_job(29'h500, 0);
      chk("z_done0", UW'(rd_done), UW'(0));
      chk("z_busy0", UW'(rd_busy), UW'(1));
      chk("z_ovf_clr", UW'(err_overflow), UW'(0));
      @(negedge ui_clk);
      chk("z_done1", UW'(rd_done), UW'(1));
      chk("z_busy1", UW'(rd_busy), UW'(1));
      @(negedge ui_clk);
      chk("z_done2", UW'(rd_done), UW'(0));
      chk("z_busy2", UW'(rd_busy), UW'(0));
      chk("z_ncmd", UW'(log_addr.size() - j_b0), UW'(0));

      // start while DDR not ready is dropped
      ddr_rdy = 1'b0;
      start_job(29'h600, 5);
      repeat (5) @(negedge ui_clk);
      chk("nrdy_busy", UW'(rd_busy), UW'(0));
      chk("nrdy_ncmd", UW'(log_addr.size() - j_b0), UW'(0));
      ddr_rdy = 1'b1;

      // reset in the middle of a job
      rdy_rand = 1;
      start_job(29'h300, 20);
      for (int i = 0; i < 200 && !(resp_busy && beats_sent >= 2); i++)
         @(negedge ui_clk);
      ui_rst = 1'b1;
      @(negedge ui_clk);
      chk("mr_cmd_valid", UW'(ddr_cmd_valid), UW'(0));
      chk("mr_cmd", UW'(ddr_cmd), UW'(2));
      chk("mr_out_valid", UW'(out_valid), UW'(0));
      chk("mr_busy", UW'(rd_busy), UW'(0));
      ui_rst = 1'b0;
      for (int i = 0; i < 200 && resp_busy; i++) @(negedge ui_clk);
      repeat (3) @(negedge ui_clk);
      chk("mr_idle", UW'(rd_busy), UW'(0));
      rb = AW'($urandom);
      start_job(rb, 3);
      finish_job("post_rst", rb, 3, 3);
      chk("post_rst_ovf", UW'(err_overflow), UW'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
